// File: rtl/pacer_pkg.sv
// rtl/pacer_pkg.sv - state type and default step periods shared by step_pacer
package pacer_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COUNT    = 2'd1,
      WAIT_ACK = 2'd2
   } pacer_state_e;

   // P0/P1 are short enough for simulation; P2/P3 are the real-time rates
   localparam int unsigned DEF_P0 = 4;
   localparam int unsigned DEF_P1 = 8;
   localparam int unsigned DEF_P2 = 1000000;
   localparam int unsigned DEF_P3 = 12500000;

endpackage

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable down-counter with zero flag; holds at zero
module down_counter #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/step_pacer.sv
// rtl/step_pacer.sv - paces enable into periodic step_req/step_ack handshakes
// and counts acknowledged steps, flagging datapath overruns.
module step_pacer #(
   parameter int unsigned GEN_W = 16,
   parameter int unsigned DIV_W = 24,
   parameter int unsigned P0    = pacer_pkg::DEF_P0,
   parameter int unsigned P1    = pacer_pkg::DEF_P1,
   parameter int unsigned P2    = pacer_pkg::DEF_P2,
   parameter int unsigned P3    = pacer_pkg::DEF_P3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             rst,
   input  logic [1:0]       period_sel,
   input  logic             step_ack,
   output logic             step_req,
   output logic             tick,
   output logic             busy,
   output logic [GEN_W-1:0] gen_count,
   output logic             overrun
);

   import pacer_pkg::*;

   pacer_state_e     state_q, state_d;
   logic             step_req_q, step_req_d;
   logic             tick_q, tick_d;
   logic             overrun_q, overrun_d;
   logic [GEN_W-1:0] gen_q, gen_d;

   logic             cnt_clr, cnt_load, cnt_dec, cnt_zero;
   logic [DIV_W-1:0] reload_val;

   // period_sel only matters at the moment a reload is requested
   always_comb begin
      unique case (period_sel)
         2'd0:    reload_val = DIV_W'(P0 - 32'd1);
         2'd1:    reload_val = DIV_W'(P1 - 32'd1);
         2'd2:    reload_val = DIV_W'(P2 - 32'd1);
         default: reload_val = DIV_W'(P3 - 32'd1);
      endcase
   end

   down_counter #(
      .W (DIV_W)
   ) u_div (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (cnt_clr),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .load_val_i (reload_val),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d    = state_q;
      step_req_d = step_req_q;
      tick_d     = 1'b0;
      overrun_d  = overrun_q;
      gen_d      = gen_q;
      cnt_clr    = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;

      if (rst) begin
         state_d    = IDLE;
         step_req_d = 1'b0;
         overrun_d  = 1'b0;
         gen_d      = '0;
         cnt_clr    = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (en) begin
                  cnt_load = 1'b1;
                  state_d  = COUNT;
               end
            end
            COUNT: begin
               if (!en) begin
                  cnt_clr = 1'b1;
                  state_d = IDLE;
               end else if (!cnt_zero) begin
                  cnt_dec = 1'b1;
               end else begin
                  step_req_d = 1'b1;
                  cnt_load   = 1'b1;
                  state_d    = WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               // divider keeps running during the handshake so spacing stays P
               if (step_ack) begin
                  step_req_d = 1'b0;
                  tick_d     = 1'b1;
                  gen_d      = gen_q + GEN_W'(1);
                  if (!en) begin
                     cnt_clr = 1'b1;
                     state_d = IDLE;
                  end else begin
                     cnt_load = cnt_zero;
                     cnt_dec  = !cnt_zero;
                     state_d  = COUNT;
                  end
               end else if (cnt_zero) begin
                  overrun_d = 1'b1;
                  cnt_load  = 1'b1;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            default: begin
               cnt_clr = 1'b1;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         step_req_q <= 1'b0;
         tick_q     <= 1'b0;
         overrun_q  <= 1'b0;
         gen_q      <= '0;
      end else begin
         state_q    <= state_d;
         step_req_q <= step_req_d;
         tick_q     <= tick_d;
         overrun_q  <= overrun_d;
         gen_q      <= gen_d;
      end
   end

   assign step_req  = step_req_q;
   assign tick      = tick_q;
   assign busy      = (state_q != IDLE);
   assign gen_count = gen_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_step_pacer.sv
// tb/tb_step_pacer.sv - scoreboard bench for step_pacer (GEN_W=4, P0=4, P1=8)
module tb_step_pacer;

   localparam int GW = 4;

   logic          clk = 1'b0;
   logic          reset, en, rst, step_ack;
   logic [1:0]    period_sel;
   logic          step_req, tick, busy, overrun;
   logic [GW-1:0] gen_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q[$];

   // reference model: elapsed-cycle count within the latched period
   int m_st, m_e, m_p, m_gen;
   bit m_req, m_tick, m_ovr;

   step_pacer #(
      .GEN_W (GW), .DIV_W (24), .P0 (4), .P1 (8), .P2 (1000000), .P3 (12500000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .rst        (rst),
      .period_sel (period_sel),
      .step_ack   (step_ack),
      .step_req   (step_req),
      .tick       (tick),
      .busy       (busy),
      .gen_count  (gen_count),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int per(input logic [1:0] s);
      case (s)
         2'd0:    return 4;
         2'd1:    return 8;
         2'd2:    return 1000000;
         default: return 12500000;
      endcase
   endfunction

   task automatic model_reset();
      m_st = 0; m_e = 0; m_p = 1; m_gen = 0;
      m_req = 0; m_tick = 0; m_ovr = 0;
   endtask

   task automatic model_edge();
      bit expire;
      expire = (m_e == m_p - 1);
      m_tick = 0;
      if (rst) begin
         model_reset();
      end else if (m_st == 0) begin
         if (en) begin m_st = 1; m_p = per(period_sel); m_e = 0; end
      end else if (m_st == 1) begin
         if (!en) m_st = 0;
         else if (expire) begin m_req = 1; m_st = 2; m_p = per(period_sel); m_e = 0; end
         else m_e++;
      end else begin
         if (step_ack) begin
            m_req = 0; m_tick = 1; m_gen = (m_gen + 1) % 16;
            m_st = en ? 1 : 0;
         end else if (expire) begin
            m_ovr = 1;
         end
         if (expire) begin m_p = per(period_sel); m_e = 0; end
         else m_e++;
      end
   endtask

   task automatic cyc();
      logic [7:0] e;
      model_edge();
      exp_q.push_back({m_req, m_tick, (m_st != 0), m_ovr, 4'(m_gen)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_eq("cycle", {step_req, tick, busy, overrun, gen_count}, e);
   endtask

   task automatic wait_req(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!step_req && n < 50);
   endtask

   task automatic do_rst();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k, ntk, t_prev, ovr_at, g0;
      reset = 1'b1; en = 1'b0; rst = 1'b0; step_ack = 1'b0; period_sel = 2'd0;
      model_reset();
      #3;
      check_eq("reset_state", {step_req, tick, busy, overrun, gen_count}, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // basic period, ack tied high
      en = 1'b1; step_ack = 1'b1;
      wait_req(n);
      check_eq("first_req_lat", n, 5);
      ntk = 0; k = 0; t_prev = 0;
      while (ntk < 3 && k < 40) begin
         cyc(); k++;
         if (tick) begin
            if (ntk > 0) check_eq("tick_gap", k - t_prev, 4);
            t_prev = k; ntk++;
         end
      end
      check_eq("gen_after_3", gen_count, 3);
      check_eq("ovr_basic", overrun, 0);

      // slow ack: overrun on 4th waiting edge, ack accepted on the 7th
      do_rst();
      step_ack = 1'b0;
      wait_req(n);
      check_eq("req_lat_slow", n, 5);
      ovr_at = 0;
      for (int w = 1; w <= 7; w++) begin
         if (w == 7) step_ack = 1'b1;
         cyc();
         if (overrun && ovr_at == 0) ovr_at = w;
      end
      check_eq("ovr_at_wait", ovr_at, 4);
      check_eq("slow_ack_tick", tick, 1);
      check_eq("slow_gen", gen_count, 1);
      step_ack = 1'b0;
      repeat (10) cyc();
      check_eq("gen_once", gen_count, 1);
      check_eq("ovr_sticky", overrun, 1);
      step_ack = 1'b1; k = 0;
      while (gen_count != 7 && k < 100) begin cyc(); k++; end
      check_eq("gen_to_7", gen_count, 7);
      step_ack = 1'b0;
      wait_req(n);
      check_eq("wait_before_rst", {step_req, overrun, gen_count}, {1'b1, 1'b1, 4'd7});
      do_rst();
      check_eq("sync_rst", {step_req, busy, overrun, gen_count}, 0);

      // pause during WAIT_ACK
      wait_req(n);
      g0 = gen_count;
      en = 1'b0;
      cyc(); cyc();
      check_eq("req_held_pause", step_req, 1);
      step_ack = 1'b1;
      cyc();
      step_ack = 1'b0;
      check_eq("pause_ack", {step_req, busy, gen_count}, {1'b0, 1'b0, 4'((g0 + 1) % 16)});
      en = 1'b1;
      wait_req(n);
      check_eq("resume_lat", n, 5);

      // gen_count wrap over 16 steps
      do_rst();
      step_ack = 1'b1; ntk = 0; k = 0;
      while (ntk < 16 && k < 120) begin
         cyc(); k++;
         if (tick) begin
            ntk++;
            check_eq("wrap_gen", gen_count, ntk % 16);
         end
      end
      check_eq("wrap_ticks", ntk, 16);

      // async reset mid-COUNT, no clock edge in between
      k = 0;
      do begin cyc(); k++; end while (!tick && k < 20);
      check_eq("pre_async", {tick, busy, gen_count}, {1'b1, 1'b1, 4'd1});
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_reset", {step_req, tick, busy, overrun, gen_count}, 0);
      en = 1'b0; step_ack = 1'b0;
      reset = 1'b0;
      model_reset();

      // period_sel change mid-COUNT, ack coincident with expiry
      period_sel = 2'd0; en = 1'b1;
      cyc(); cyc();
      period_sel = 2'd1;
      wait_req(n);
      check_eq("sel_cur_period", n + 2, 5);
      repeat (7) cyc();
      step_ack = 1'b1;
      cyc();
      step_ack = 1'b0;
      check_eq("ack_at_expiry", {tick, overrun}, {1'b1, 1'b0});
      wait_req(n);
      check_eq("sel_next_period", n, 8);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
